// File: rtl/datamux_pkg.sv
// Definitions shared by the datamux / dataconcentrator / data_demux path:
// tagged-word type, source-ID field position and source-ID codes.
package datamux_pkg;

    localparam int WORD_W     = 64;
    localparam int SRC_ID_LSB = 56;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [3:0] {
        DEBUG   = 4'd0,
        ATLASS1 = 4'd1,
        ATLASS2 = 4'd2,
        ATLASS3 = 4'd3,
        ATLASS4 = 4'd4,
        ATLASS5 = 4'd5
    } src_id_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_POP  = 2'd1,
        ST_SEND = 2'd2
    } demux_state_e;

    // Extract the 4-bit source ID from a tagged word.
    function automatic logic [3:0] get_src_id(input word_t w, input int lsb);
        return w[lsb +: 4];
    endfunction

endpackage

// File: rtl/data_demux_sat_counter.sv
// Saturating up-counter with a synchronous clear; it holds at all-ones and never wraps.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count register: async reset, sync clear, increment until saturated.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= {W{1'b0}};
        end else if (clr) begin
            count <= {W{1'b0}};
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/data_demux.sv
// Pops tagged words from an FWFT FIFO, decodes the source ID and hands each word
// to its sink over a valid/ready handshake; unroutable words are counted and dropped.
module data_demux #(
    parameter int N_DEST     = 6,
    parameter int SRC_ID_LSB = datamux_pkg::SRC_ID_LSB,
    parameter int CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [N_DEST-1:0] dest_mask,
    input  logic [63:0]       fifo_dout,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    output logic [63:0]       out_data,
    output logic [N_DEST-1:0] out_valid,
    input  logic [N_DEST-1:0] out_ready,
    output logic [CNT_W-1:0]  fwd_count,
    output logic [CNT_W-1:0]  drop_count,
    output logic              busy
);

    import datamux_pkg::*;

    demux_state_e      state_r;
    demux_state_e      state_s;
    word_t             hold_r;
    word_t             hold_s;
    logic              rd_en_s;
    word_t             data_s;
    logic [N_DEST-1:0] valid_s;
    logic [3:0]        id_s;
    logic [N_DEST-1:0] route_s;
    logic              ready_hit_s;
    logic              fwd_inc_s;
    logic              drop_inc_s;

    assign id_s = get_src_id(hold_r, SRC_ID_LSB);

    // One-hot route for the held word; zero when the ID is out of range or the sink is masked.
    always_comb begin
        route_s = {N_DEST{1'b0}};
        for (int k = 0; k < N_DEST; k++) begin
            route_s[k] = dest_mask[k] & (id_s == 4'(k));
        end
    end

    // out_valid is one-hot on the addressed sink, so only that sink's ready can complete a transfer.
    assign ready_hit_s = |(out_valid & out_ready);

    // Next-state and next-output logic.
    always_comb begin
        state_s    = state_r;
        hold_s     = hold_r;
        rd_en_s    = 1'b0;
        data_s     = out_data;
        valid_s    = out_valid;
        fwd_inc_s  = 1'b0;
        drop_inc_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (enable && !fifo_empty) begin
                    hold_s  = fifo_dout;
                    rd_en_s = 1'b1;
                    state_s = ST_POP;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_POP: begin
                if (route_s != {N_DEST{1'b0}}) begin
                    data_s  = hold_r;
                    valid_s = route_s;
                    state_s = ST_SEND;
                end else begin
                    drop_inc_s = 1'b1;
                    state_s    = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (ready_hit_s) begin
                    valid_s   = {N_DEST{1'b0}};
                    fwd_inc_s = 1'b1;
                    state_s   = ST_IDLE;
                end else begin
                    state_s = ST_SEND;
                end
            end
            default: begin
                valid_s = {N_DEST{1'b0}};
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, hold and output registers; a reset discards any word in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            hold_r     <= {WORD_W{1'b0}};
            fifo_rd_en <= 1'b0;
            out_data   <= 64'd0;
            out_valid  <= {N_DEST{1'b0}};
            busy       <= 1'b0;
        end else begin
            state_r    <= state_s;
            hold_r     <= hold_s;
            fifo_rd_en <= rd_en_s;
            out_data   <= data_s;
            out_valid  <= valid_s;
            busy       <= (state_s != ST_IDLE);
        end
    end

    sat_counter #(.W(CNT_W)) u_fwd_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .inc   (fwd_inc_s),
        .count (fwd_count)
    );

    sat_counter #(.W(CNT_W)) u_drop_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .inc   (drop_inc_s),
        .count (drop_count)
    );

endmodule

// File: tb/tb_data_demux.sv
// Directed bench for data_demux: FWFT FIFO model, scoreboard of expected deliveries,
// routing, drop, backpressure, throughput, enable and reset cases.
module tb_data_demux;

    import datamux_pkg::*;

    localparam int N_DEST = 6;
    localparam int CNT_W  = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              enable;
    logic [N_DEST-1:0] dest_mask;
    logic [63:0]       fifo_dout;
    logic              fifo_empty;
    logic              fifo_rd_en;
    logic [63:0]       out_data;
    logic [N_DEST-1:0] out_valid;
    logic [N_DEST-1:0] out_ready;
    logic [CNT_W-1:0]  fwd_count;
    logic [CNT_W-1:0]  drop_count;
    logic              busy;
    logic              sat_inc;
    logic              sat_clr;
    logic [2:0]        sat_count;

    always #5 clk = ~clk;

    data_demux #(.N_DEST(N_DEST), .SRC_ID_LSB(56), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .dest_mask  (dest_mask),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fwd_count  (fwd_count),
        .drop_count (drop_count),
        .busy       (busy)
    );

    sat_counter #(.W(3)) u_sat (
        .clk   (clk),
        .rst   (rst),
        .clr   (sat_clr),
        .inc   (sat_inc),
        .count (sat_count)
    );

    typedef struct {
        int    sink;
        word_t data;
    } exp_t;

    exp_t  exp_q[$];
    word_t fifo_q[$];
    int    total = 0;
    int    bad = 0;
    int    exp_fwd = 0;
    int    exp_drop = 0;
    int    rd_pulses = 0;
    int    valid_cycles = 0;
    logic  prev_rd = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic word_t mk_word(input logic [3:0] id, input logic [15:0] tag);
        return {4'h0, id, 8'h5A, 32'h0000_0000, tag};
    endfunction

    task automatic refresh();
        fifo_empty = (fifo_q.size() == 0);
        fifo_dout  = fifo_empty ? 64'd0 : fifo_q[0];
    endtask

    task automatic push_word(input word_t w);
        logic [3:0] id;
        exp_t       e;
        id = w[59:56];
        fifo_q.push_back(w);
        if (id < 4'd6 && dest_mask[id[2:0]]) begin
            e.sink = int'(id);
            e.data = w;
            exp_q.push_back(e);
        end else begin
            exp_drop++;
        end
        refresh();
    endtask

    // One clock: check invariants and handshakes at negedge, apply the FIFO pop after posedge.
    task automatic step();
        logic pop_pend;
        int   k;
        exp_t e;
        @(negedge clk);
        if (!rst) begin
            chk("onehot", 64'($countones(out_valid) <= 1), 64'd1);
            chk("rd_en_pair", {63'd0, fifo_rd_en & prev_rd}, 64'd0);
            if (fifo_rd_en) rd_pulses++;
            if (out_valid != '0) valid_cycles++;
            if ((out_valid & out_ready) != '0) begin
                k = -1;
                for (int i = 0; i < N_DEST; i++) if (out_valid[i]) k = i;
                if (exp_q.size() == 0) begin
                    chk("unexpected_xfer", {58'd0, out_valid}, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("xfer_sink", 64'(k), 64'(e.sink));
                    chk("xfer_data", out_data, e.data);
                    exp_fwd++;
                end
            end
        end
        prev_rd  = fifo_rd_en;
        pop_pend = fifo_rd_en;
        @(posedge clk);
        #1;
        if (pop_pend && fifo_q.size() > 0) begin
            void'(fifo_q.pop_front());
            refresh();
        end
    endtask

    task automatic drain(input int budget, input string tag);
        int n;
        n = 0;
        while (!(fifo_q.size() == 0 && busy === 1'b0 && exp_q.size() == 0) && n < budget) begin
            step();
            n++;
        end
        chk({tag, "_drain"}, 64'(n < budget), 64'd1);
        chk({tag, "_fwd"}, 64'(fwd_count), 64'(exp_fwd));
        chk({tag, "_drop"}, 64'(drop_count), 64'(exp_drop));
    endtask

    initial begin
        int r0;
        int v0;
        int n;
        int target;

        rst       = 1'b1;
        enable    = 1'b0;
        dest_mask = 6'h3F;
        out_ready = 6'h00;
        sat_inc   = 1'b0;
        sat_clr   = 1'b0;
        refresh();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rd_en", {63'd0, fifo_rd_en}, 64'd0);
        chk("rst_valid", {58'd0, out_valid}, 64'd0);
        chk("rst_data", out_data, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_fwd", 64'(fwd_count), 64'd0);
        chk("rst_drop", 64'(drop_count), 64'd0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        enable    = 1'b1;
        out_ready = 6'h3F;

        // Routing: one word per source ID, all sinks ready.
        for (int k = 0; k < 6; k++) push_word(mk_word(4'(k), 16'(k)));
        drain(60, "t2");
        chk("t2_fwd6", 64'(fwd_count), 64'd6);

        // Drop: out-of-range ID and a masked sink.
        dest_mask = 6'b110111;
        r0 = rd_pulses;
        v0 = valid_cycles;
        push_word(mk_word(4'd7, 16'h0007));
        push_word(mk_word(4'd3, 16'h0003));
        drain(30, "t3");
        chk("t3_drop2", 64'(drop_count), 64'd2);
        chk("t3_pops", 64'(rd_pulses - r0), 64'd2);
        chk("t3_no_valid", 64'(valid_cycles - v0), 64'd0);
        dest_mask = 6'h3F;

        // Backpressure on sink 2 for 10 cycles; other ready bits stay high.
        out_ready = 6'b111011;
        push_word(mk_word(4'd2, 16'h0004));
        push_word(mk_word(4'd1, 16'h0041));
        n = 0;
        while (out_valid[2] !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        chk("t4_valid_up", {58'd0, out_valid}, 64'h04);
        r0 = rd_pulses;
        repeat (10) begin
            step();
            chk("t4_data_stable", out_data, mk_word(4'd2, 16'h0004));
            chk("t4_valid_stable", {58'd0, out_valid}, 64'h04);
        end
        chk("t4_no_pop", 64'(rd_pulses - r0), 64'd0);
        out_ready = 6'h3F;
        step();
        chk("t4_released", {58'd0, out_valid}, 64'd0);
        chk("t4_fwd", 64'(fwd_count), 64'(exp_fwd));
        drain(30, "t4");

        // Throughput: 100 back-to-back words take 3 cycles each.
        target = exp_fwd + 100;
        for (int i = 0; i < 100; i++) push_word(mk_word(4'(i % 6), 16'(i)));
        n = 0;
        while (fwd_count !== 32'(target) && n < 400) begin
            step();
            n++;
        end
        chk("t5_cycles", 64'(n), 64'd300);
        drain(10, "t5");

        // Enable drops while a word is in SEND.
        push_word(mk_word(4'd4, 16'h0044));
        push_word(mk_word(4'd5, 16'h0055));
        n = 0;
        while (out_valid === '0 && n < 10) begin
            step();
            n++;
        end
        enable = 1'b0;
        r0 = rd_pulses;
        step();
        repeat (10) begin
            step();
            chk("t6_rd_en_low", {63'd0, fifo_rd_en}, 64'd0);
            chk("t6_idle", {63'd0, busy}, 64'd0);
        end
        chk("t6_no_pop", 64'(rd_pulses - r0), 64'd0);
        chk("t6_fwd", 64'(fwd_count), 64'(exp_fwd));
        enable = 1'b1;
        drain(20, "t6");

        // Reset asserted mid-SEND clears outputs and counters without waiting for a clock edge.
        out_ready = 6'h00;
        push_word(mk_word(4'd3, 16'hBEEF));
        n = 0;
        while (out_valid[3] !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        chk("t1_in_send", {58'd0, out_valid}, 64'h08);
        #2;
        rst = 1'b1;
        #1;
        chk("t1_valid", {58'd0, out_valid}, 64'd0);
        chk("t1_rd_en", {63'd0, fifo_rd_en}, 64'd0);
        chk("t1_fwd", 64'(fwd_count), 64'd0);
        chk("t1_drop", 64'(drop_count), 64'd0);
        chk("t1_busy", {63'd0, busy}, 64'd0);
        exp_q.delete();
        fifo_q.delete();
        refresh();
        exp_fwd  = 0;
        exp_drop = 0;
        prev_rd  = 1'b0;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 6'h3F;
        push_word(mk_word(4'd0, 16'h0D0D));
        drain(20, "t1_after");

        // Saturation of the counter building block at a small width.
        sat_inc = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        sat_inc = 1'b0;
        chk("sat_hold", {61'd0, sat_count}, 64'd7);
        sat_clr = 1'b1;
        @(posedge clk);
        #1;
        sat_clr = 1'b0;
        chk("sat_clr", {61'd0, sat_count}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
